// File: rtl/bfp_block_packer.sv
// Frames BFP-normalised I/Q samples into header + sample beats on a valid/ready stream.
// Optional per-block XOR trailer beat when BFP_PACK_CHECKSUM_EN is defined.
module bfp_block_packer #(
    parameter int WIDTH      = 16,
    parameter int BLOCK_SIZE = 256,
    parameter int FIFO_DEPTH = 32,
    parameter int EXP_W      = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     i_in,
    input  logic [WIDTH-1:0]     q_in,
    input  logic [EXP_W-1:0]     exp_in,
    input  logic                 valid_in,
    output logic [2*WIDTH-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_hdr,
    output logic                 m_last,
    output logic                 ovf,
    output logic                 exp_err,
    input  logic                 err_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(BLOCK_SIZE);
    localparam int IDX_W = 2 * WIDTH - 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_SIZE - 1);

    typedef struct packed {
        logic             sof;
        logic             eof;
        logic [EXP_W-1:0] exp;
        logic [WIDTH-1:0] i;
        logic [WIDTH-1:0] q;
    } entry_t;

    typedef enum logic [1:0] {S_HDR, S_DATA, S_TRL} state_t;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fill;
    logic             empty, full, push, pop;
    entry_t           head;

    logic [CNT_W-1:0] in_cnt;
    logic [EXP_W-1:0] blk_exp;

    state_t           state;
    logic             mid;
    logic             resync;
    logic [IDX_W-1:0] blk_idx;

`ifdef BFP_PACK_CHECKSUM_EN
    logic [2*WIDTH-1:0] csum;
`endif

    assign empty = (fill == '0);
    assign full  = (fill == (PTR_W + 1)'(FIFO_DEPTH));
    assign head  = mem[rd_ptr];
    // a pop in the same cycle frees a slot, so a full FIFO still accepts
    assign push  = valid_in && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{sof: (in_cnt == '0), eof: (in_cnt == LAST_CNT),
                             exp: exp_in, i: i_in, q: q_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    // in_cnt runs on every valid_in, dropped or not, to keep block alignment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            blk_exp <= '0;
            ovf     <= 1'b0;
            exp_err <= 1'b0;
        end else begin
            if (valid_in) in_cnt <= (in_cnt == LAST_CNT) ? '0 : in_cnt + 1'b1;
            if (valid_in && in_cnt == '0) blk_exp <= exp_in;
            ovf     <= (valid_in && full && !pop) || (ovf && !err_clr);
            exp_err <= (valid_in && in_cnt != '0 && exp_in != blk_exp) || (exp_err && !err_clr);
        end
    end

    // Beats come straight off the FIFO head so the header appears the cycle after the sof write
    always_comb begin
        m_valid = 1'b0;
        m_hdr   = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        pop     = 1'b0;
        resync  = 1'b0;
        case (state)
            S_HDR: if (!empty) begin
                if (head.sof) begin
                    m_valid = 1'b1;
                    m_hdr   = 1'b1;
                    m_data  = {blk_idx, 8'(head.exp)};
                end else begin
                    pop = 1'b1;
                end
            end
            S_DATA: if (!empty) begin
                // sof after the first beat means this block lost its eof
                if (head.sof && mid) begin
                    resync = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_data  = {head.i, head.q};
`ifndef BFP_PACK_CHECKSUM_EN
                    m_last  = head.eof;
`endif
                    pop     = m_ready;
                end
            end
`ifdef BFP_PACK_CHECKSUM_EN
            S_TRL: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data  = csum;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_HDR;
            mid     <= 1'b0;
            blk_idx <= '0;
        end else begin
            case (state)
                S_HDR: if (m_valid && m_ready) begin
                    blk_idx <= blk_idx + 1'b1;
                    mid     <= 1'b0;
                    state   <= S_DATA;
                end
                S_DATA: if (resync) begin
                    state <= S_HDR;
                end else if (pop) begin
                    mid <= 1'b1;
`ifdef BFP_PACK_CHECKSUM_EN
                    if (head.eof) state <= S_TRL;
`else
                    if (head.eof) state <= S_HDR;
`endif
                end
                S_TRL: if (m_ready) state <= S_HDR;
                default: state <= S_HDR;
            endcase
        end
    end

`ifdef BFP_PACK_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= '0;
        else if (state == S_HDR && m_valid && m_ready)
            csum <= '0;
        else if (state == S_DATA && pop)
            csum <= csum ^ {head.i, head.q};
    end
`endif

endmodule

// File: doc/bfp_block_packer.md
Name: bfp_block_packer

Overview:
- Sits directly downstream of the BFP normaliser: consumes normalised I/Q samples plus block exponent and frames them into a valid/ready stream for the transport/DMA stage.
- Each block is emitted as one header beat (exponent + block index) followed by BLOCK_SIZE sample beats, with last on the final beat.
- An internal FIFO absorbs downstream backpressure; the input side has no backpressure.

Parameters:
- WIDTH, 16, sample width per rail; must be 8..255.
- BLOCK_SIZE, 256, samples per block; must be at least 2.
- FIFO_DEPTH, 32, entries in the internal buffer; must be a power of 2, at least 4.
- EXP_W, $clog2(WIDTH+1), exponent width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_in  in  WIDTH  normalised I sample.
- q_in  in  WIDTH  normalised Q sample.
- exp_in  in  EXP_W  block exponent accompanying the sample.
- valid_in  in  1  sample qualifier; no ready is returned.
- m_data  out  2*WIDTH  output beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_hdr  out  1  current beat is a header.
- m_last  out  1  current beat is the final beat of the block.
- ovf  out  1  sticky: an input sample was dropped because the FIFO was full.
- exp_err  out  1  sticky: exponent changed inside a block.
- err_clr  in  1  synchronous clear of ovf and exp_err.

Behaviour:
- **Reset values:** all outputs 0; FIFO empty; counters 0; FSM in S_HDR; block index 0. Reset mid-block discards all buffered data; the next accepted sample starts a new block.
- **Input side:**
  - in_cnt counts accepted valid_in samples modulo BLOCK_SIZE.
  - Each sample is written as the FIFO entry {sof, eof, exp_in, i_in, q_in}.
  - sof=1 when in_cnt==0; eof=1 when in_cnt==BLOCK_SIZE-1.
  - in_cnt advances on every valid_in, including dropped samples, so block alignment is kept.
- **Exponent check:**
  - On a sof sample, exp_in is captured into blk_exp.
  - Any later valid_in in the same block with exp_in != blk_exp sets exp_err.
- **Overflow:** valid_in while the FIFO is full (and no pop in the same cycle) drops the sample and sets ovf. A full FIFO with a simultaneous pop accepts the write.
- **Sticky flags:** err_clr clears both flags. If a set event occurs in the same cycle as err_clr, set wins.
- **FIFO timing:** registered, first-word fall-through; an entry written in cycle N is visible at the head in N+1. Simultaneous push/pop is allowed at any fill level except empty-pop.
- **Output FSM:**
  - S_HDR: m_valid=1 when the head entry has sof=1.
    - Beat: m_hdr=1, m_last=0, m_data = {blk_idx[2*WIDTH-9:0], 8'(head exp)}.
    - The head is not popped.
    - On m_valid&&m_ready: blk_idx increments (wraps at 2^(2*WIDTH-8)), go to S_DATA.
    - If the head has sof=0 (orphan after overflow), pop it silently without asserting m_valid.
  - S_DATA: m_valid = FIFO non-empty; m_data = {i,q}; m_hdr=0; m_last = head eof.
    - Pop on m_valid&&m_ready.
    - If the popped entry has eof=1, go to S_HDR (or S_TRL when BFP_PACK_CHECKSUM_EN is defined).
    - If the head has sof=1 while in S_DATA (eof was lost), go to S_HDR without popping; the broken block has no m_last.
- **Stream rules:**
  - m_data, m_hdr and m_last are held stable while m_valid&&!m_ready.
  - m_valid is never dropped without a handshake.
- **Latency:** first sof sample in cycle N gives the header at N+1 and that sample at N+2 (with m_ready=1).
- **Throughput:** one extra output beat per block. Sustained input must include at least 1 idle cycle per block, otherwise the FIFO eventually overflows.

Optional Feature:
- Macro: BFP_PACK_CHECKSUM_EN.
- **When defined:**
  - A running XOR of all sample beats' m_data is accumulated per block.
  - After the eof sample, state S_TRL emits one trailer beat: m_data = checksum, m_hdr=0, m_last=1.
  - The eof sample beat then has m_last=0.
  - The checksum register is cleared on header acceptance.
- **When undefined:** no trailer; m_last is asserted on the eof sample; no checksum logic exists.

Test Plan:
- **Basic framing:** WIDTH=16, BLOCK_SIZE=4, m_ready=1; feed 4 samples i=1..4, q=0x10..0x13, exp=3 → beats: header 0x00000003 (m_hdr=1), then 0x00010010..0x00040013 with m_last only on the 4th. Second block header = 0x00000103.
- **Backpressure:** same stream with m_ready toggling 1,0,0,1 → every beat delivered once, in order; m_data is stable through stall cycles; ovf stays 0.
- **Overflow:** FIFO_DEPTH=4, m_ready=0, 6 samples → ovf=1 after the 5th sample. Then m_ready=1: 4 entries drain; err_clr clears ovf the next cycle.
- **Exponent error:** exp=3 for samples 0-1 and exp=4 for sample 2 → exp_err=1 one cycle after sample 2; the header still carries exponent 3.
- **Reset mid-block:** assert rst_n=0 after 2 of 4 samples → all outputs 0. After release, a 4-sample block produces header idx 0 plus 4 samples.
- **Checksum (BFP_PACK_CHECKSUM_EN defined):** samples 0x00010010, 0x00020020, 0x00040040, 0x00080080 → trailer 0x000F00F0 with m_last=1; the 4th sample beat has m_last=0.
